mdu_hilo: RTL

- Multiply/divide unit in the E stage of the P7 five-stage MIPS pipeline.
- Owns the HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Produces the busy indication consumed by the D-stage stall unit. The stall unit holds any HI/LO instruction in D while this block is occupied.
- Runs a fixed-latency multi-cycle sequence and honours the exception/interrupt request so that a flushed instruction never commits.

---
 rtl/mdu_hilo_pkg.sv | 26 ++
 rtl/mdu_hilo_if.sv | 16 +
 rtl/mdu_hilo.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies, counter width and the IDLE/RUN state type.
package mdu_hilo_pkg;

  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for a multi-cycle sequence.
  function automatic logic is_md_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Bundle between the E stage and the multiply/divide unit.
// start qualifies md_op/A/B/req for one cycle; there is no ready: busy tells
// the D-stage stall unit to hold any HI/LO instruction until the unit is free.
interface mdu_hilo_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        req;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output start, md_op, A, B, req, input busy, HI, LO);
  modport slave  (input start, md_op, A, B, req, output busy, HI, LO);
endinterface

// File: rtl/mdu_hilo.sv
// HI/LO owner for the P7 pipeline: fixed-latency MULT/DIV sequence with the
// result held in a pending register and committed when the counter expires.
module mdu_hilo
  import mdu_hilo_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  mdu_hilo_if.slave   mdu,
  output mdu_state_e  o_dbg_state
);

  mdu_state_e       r_state;
  mdu_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_pend_hi;
  logic [31:0]      r_pend_lo;
  logic             r_div_zero;

  logic             w_accept;
  logic             w_launch;
  logic             w_commit;
  logic             w_is_div;
  logic             w_b_zero;
  logic [31:0]      w_b_safe;
  logic [63:0]      w_prod_s;
  logic [63:0]      w_prod_u;
  logic [31:0]      w_q_s;
  logic [31:0]      w_r_s;
  logic [31:0]      w_q_u;
  logic [31:0]      w_r_u;
  logic [31:0]      w_pend_hi;
  logic [31:0]      w_pend_lo;

  assign w_accept = mdu.start && !mdu.req && (r_state == ST_IDLE);
  assign w_launch = w_accept && is_md_op(mdu.md_op);
  assign w_commit = (r_state == ST_RUN) && (r_cnt == CNT_W'(1));
  assign w_is_div = (mdu.md_op == MD_DIV) || (mdu.md_op == MD_DIVU);
  assign w_b_zero = (mdu.B == 32'd0);

  // Divisor forced non-zero so the quotient never goes X; the result is
  // discarded anyway when the real divisor is zero.
  assign w_b_safe = w_b_zero ? 32'd1 : mdu.B;

  assign w_prod_s = $signed({{32{mdu.A[31]}}, mdu.A}) * $signed({{32{mdu.B[31]}}, mdu.B});
  assign w_prod_u = {32'd0, mdu.A} * {32'd0, mdu.B};
  assign w_q_s    = $signed(mdu.A) / $signed(w_b_safe);
  assign w_r_s    = $signed(mdu.A) % $signed(w_b_safe);
  assign w_q_u    = mdu.A / w_b_safe;
  assign w_r_u    = mdu.A % w_b_safe;

  always_comb begin
    w_pend_hi = w_prod_u[63:32];
    w_pend_lo = w_prod_u[31:0];
    case (mdu.md_op)
      MD_MULT: begin
        w_pend_hi = w_prod_s[63:32];
        w_pend_lo = w_prod_s[31:0];
      end
      MD_DIV: begin
        w_pend_hi = w_r_s;
        w_pend_lo = w_q_s;
      end
      MD_DIVU: begin
        w_pend_hi = w_r_u;
        w_pend_lo = w_q_u;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_launch) w_state_next = ST_RUN;
      ST_RUN:  if (w_commit) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_pend_hi  <= '0;
      r_pend_lo  <= '0;
      r_div_zero <= 1'b0;
    end else begin
      if (w_launch) begin
        r_pend_hi  <= w_pend_hi;
        r_pend_lo  <= w_pend_lo;
        r_div_zero <= w_is_div && w_b_zero;
        r_cnt      <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (r_state == ST_RUN) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_commit && !r_div_zero) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      // Moves only happen in IDLE, so they never collide with a commit.
      if (w_accept && (mdu.md_op == MD_MTHI)) r_hi <= mdu.A;
      if (w_accept && (mdu.md_op == MD_MTLO)) r_lo <= mdu.A;
    end
  end

  assign mdu.busy    = (mdu.start && !mdu.req && is_md_op(mdu.md_op)) || (r_state == ST_RUN);
  assign mdu.HI      = r_hi;
  assign mdu.LO      = r_lo;
  assign o_dbg_state = r_state;

  a_no_start_in_run: assert property (@(posedge clk) disable iff (!reset)
    !(mdu.start && (r_state == ST_RUN)));

endmodule
